// File: rtl/test_sequencer.sv
// Regression sequencer: runs enabled test engines in ascending index order,
// issues a one-cycle start to each, collects pass/fail/timeout outcomes and keeps tallies.
module test_sequencer #(
  parameter int unsigned NUM_TESTS = 10,
  parameter int unsigned ID_W      = 8,
  parameter int unsigned TMO_W     = 24,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                 sclk,
  input  logic                 sclk_reset,
  input  logic                 run,
  input  logic                 abort,
  input  logic [NUM_TESTS-1:0] test_mask,
  input  logic                 stop_on_fail,
  input  logic [TMO_W-1:0]     timeout_cycles,
  output logic [NUM_TESTS-1:0] test_start,
  input  logic [NUM_TESTS-1:0] test_done,
  input  logic [NUM_TESTS-1:0] test_pass,
  output logic                 busy,
  output logic                 done,
  output logic [ID_W-1:0]      cur_test,
  output logic [CNT_W-1:0]     pass_cnt,
  output logic [CNT_W-1:0]     fail_cnt,
  output logic [CNT_W-1:0]     tmo_cnt,
  output logic [NUM_TESTS-1:0] fail_vec,
  output logic [ID_W-1:0]      first_fail,
  output logic                 aborted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_START,
    S_WAIT,
    S_NEXT,
    S_FINISH
  } state_t;

  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_TESTS - 1);

  state_t               r_state;
  state_t               w_next;
  logic [NUM_TESTS-1:0] r_mask;
  logic                 r_stop;
  logic [TMO_W-1:0]     r_tmo;
  logic [TMO_W-1:0]     r_timer;
  logic [NUM_TESTS-1:0] r_test_start;
  logic                 r_busy;
  logic                 r_done;
  logic [ID_W-1:0]      r_cur;
  logic [CNT_W-1:0]     r_pass_cnt;
  logic [CNT_W-1:0]     r_fail_cnt;
  logic [CNT_W-1:0]     r_tmo_cnt;
  logic [NUM_TESTS-1:0] r_fail_vec;
  logic [ID_W-1:0]      r_first_fail;
  logic                 r_aborted;
  logic                 r_last_bad;

  logic [NUM_TESTS-1:0] w_sel;
  logic                 w_last;
  logic                 w_mask_hit;
  logic                 w_done_hit;
  logic                 w_pass_hit;
  logic                 w_abort;
  logic                 w_pass_evt;
  logic                 w_fail_evt;
  logic                 w_tmo_evt;

  // One-hot select of the current slot; avoids indexing with the wider ID_W value.
  always_comb begin
    w_sel      = NUM_TESTS'(1) << r_cur;
    w_last     = (r_cur == LAST_ID);
    w_mask_hit = |(r_mask & w_sel);
    w_done_hit = |(test_done & w_sel);
    w_pass_hit = |(test_pass & w_sel);
    w_abort    = abort && (r_state inside {S_SCAN, S_START, S_WAIT, S_NEXT});
    w_pass_evt = (r_state == S_WAIT) && !abort && w_done_hit && w_pass_hit;
    w_fail_evt = (r_state == S_WAIT) && !abort && w_done_hit && !w_pass_hit;
    w_tmo_evt  = (r_state == S_WAIT) && !abort && !w_done_hit && (r_tmo != '0) &&
                 (r_timer == r_tmo - TMO_W'(1));
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (run) w_next = S_SCAN;
      S_SCAN: begin
        if (w_mask_hit)  w_next = S_START;
        else if (w_last) w_next = S_FINISH;
      end
      S_START:  w_next = S_WAIT;
      S_WAIT:   if (w_pass_evt || w_fail_evt || w_tmo_evt) w_next = S_NEXT;
      S_NEXT: begin
        if ((r_stop && r_last_bad) || w_last) w_next = S_FINISH;
        else                                  w_next = S_SCAN;
      end
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
    if (w_abort) w_next = S_FINISH;
  end

  // Strobes are registered from the next state so they align with START/FINISH.
  always_ff @(posedge sclk) begin
    if (sclk_reset) begin
      r_state      <= S_IDLE;
      r_mask       <= '0;
      r_stop       <= 1'b0;
      r_tmo        <= '0;
      r_timer      <= '0;
      r_test_start <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_cur        <= '0;
      r_pass_cnt   <= '0;
      r_fail_cnt   <= '0;
      r_tmo_cnt    <= '0;
      r_fail_vec   <= '0;
      r_first_fail <= '1;
      r_aborted    <= 1'b0;
      r_last_bad   <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_test_start <= (w_next == S_START) ? w_sel : '0;
      r_done       <= (w_next == S_FINISH);
      r_busy       <= (w_next != S_IDLE);
      if (w_abort) r_aborted <= 1'b1;
      if (r_state == S_IDLE && run) begin
        r_mask       <= test_mask;
        r_stop       <= stop_on_fail;
        r_tmo        <= timeout_cycles;
        r_pass_cnt   <= '0;
        r_fail_cnt   <= '0;
        r_tmo_cnt    <= '0;
        r_fail_vec   <= '0;
        r_aborted    <= 1'b0;
        r_last_bad   <= 1'b0;
        r_first_fail <= '1;
        r_cur        <= '0;
      end
      if ((r_state == S_SCAN || r_state == S_NEXT) && w_next == S_SCAN)
        r_cur <= r_cur + ID_W'(1);
      if (r_state == S_START) r_timer <= '0;
      if (r_state == S_WAIT)  r_timer <= r_timer + TMO_W'(1);
      if (w_pass_evt && r_pass_cnt != '1) r_pass_cnt <= r_pass_cnt + CNT_W'(1);
      if (w_fail_evt && r_fail_cnt != '1) r_fail_cnt <= r_fail_cnt + CNT_W'(1);
      if (w_tmo_evt && r_tmo_cnt != '1)   r_tmo_cnt  <= r_tmo_cnt + CNT_W'(1);
      if (w_fail_evt || w_tmo_evt) begin
        r_fail_vec <= r_fail_vec | w_sel;
        if (r_fail_vec == '0) r_first_fail <= r_cur;
      end
      if (w_pass_evt || w_fail_evt || w_tmo_evt)
        r_last_bad <= w_fail_evt || w_tmo_evt;
    end
  end

  assign test_start = r_test_start;
  assign busy       = r_busy;
  assign done       = r_done;
  assign cur_test   = r_cur;
  assign pass_cnt   = r_pass_cnt;
  assign fail_cnt   = r_fail_cnt;
  assign tmo_cnt    = r_tmo_cnt;
  assign fail_vec   = r_fail_vec;
  assign first_fail = r_first_fail;
  assign aborted    = r_aborted;

endmodule

// File: tb/tb_test_sequencer.sv
// Directed bench for test_sequencer: a per-slot engine model replies after a
// programmable delay; each step checks tallies, ordering and strobes against hand-computed values.
module tb_test_sequencer;
  localparam int NT = 10;

  logic          sclk = 1'b0;
  logic          sclk_reset = 1'b1;
  logic          run = 1'b0;
  logic          abort = 1'b0;
  logic          stop_on_fail = 1'b0;
  logic [NT-1:0] test_mask = '0;
  logic [23:0]   timeout_cycles = '0;
  logic [NT-1:0] test_done = '0;
  logic [NT-1:0] test_pass = '0;
  logic [NT-1:0] test_start;
  logic [NT-1:0] fail_vec;
  logic          busy, done, aborted;
  logic [7:0]    cur_test, pass_cnt, fail_cnt, tmo_cnt, first_fail;

  int n_cmp = 0;
  int n_err = 0;
  int rsp_delay[NT];
  logic rsp_pass[NT];
  int rsp_cnt[NT];
  int start_log[$];
  int start_cyc[$];
  int cyc = 0;
  int done_cnt = 0;
  int start_bad = 0;
  logic [NT-1:0] prev_start = '0;

  always #5 sclk = ~sclk;

  test_sequencer #(.NUM_TESTS(NT), .ID_W(8), .TMO_W(24), .CNT_W(8)) dut (
    .sclk(sclk), .sclk_reset(sclk_reset), .run(run), .abort(abort),
    .test_mask(test_mask), .stop_on_fail(stop_on_fail), .timeout_cycles(timeout_cycles),
    .test_start(test_start), .test_done(test_done), .test_pass(test_pass),
    .busy(busy), .done(done), .cur_test(cur_test), .pass_cnt(pass_cnt),
    .fail_cnt(fail_cnt), .tmo_cnt(tmo_cnt), .fail_vec(fail_vec),
    .first_fail(first_fail), .aborted(aborted)
  );

  // Engine model: a start arms slot i; after rsp_delay[i] cycles it pulses done with rsp_pass[i].
  always @(negedge sclk) begin
    cyc++;
    test_done = '0;
    test_pass = '0;
    for (int i = 0; i < NT; i++) begin
      if (rsp_cnt[i] != 0) begin
        rsp_cnt[i]--;
        if (rsp_cnt[i] == 0) begin
          test_done[i] = 1'b1;
          test_pass[i] = rsp_pass[i];
        end
      end
    end
    if (done === 1'b1) done_cnt++;
    if (test_start !== '0) begin
      if ($countones(test_start) != 1 || prev_start !== '0) start_bad++;
      for (int i = 0; i < NT; i++) begin
        if (test_start[i]) begin
          start_log.push_back(i);
          start_cyc.push_back(cyc);
          if (rsp_delay[i] != 0) rsp_cnt[i] = rsp_delay[i];
        end
      end
    end
    prev_start = test_start;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_rsp(input int d, input logic p);
    for (int i = 0; i < NT; i++) begin
      rsp_delay[i] = d;
      rsp_pass[i]  = p;
    end
  endtask

  task automatic do_run(input logic [NT-1:0] m, input logic s, input logic [23:0] t);
    @(negedge sclk);
    test_mask = m;
    stop_on_fail = s;
    timeout_cycles = t;
    run = 1'b1;
    @(negedge sclk);
    run = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int k = 0;
    while (done !== 1'b1 && k < budget) begin
      @(negedge sclk);
      k++;
    end
    chk({tag, "_done_seen"}, 32'(done), 32'd1);
  endtask

  // Called on the done cycle: final tallies, then busy drop and a single done pulse.
  task automatic end_chk(input string tag, input int dc0, input int ep, input int ef,
                         input int et, input logic [NT-1:0] efv, input logic [7:0] eff,
                         input logic eab);
    chk({tag, "_pass_cnt"}, 32'(pass_cnt), 32'(ep));
    chk({tag, "_fail_cnt"}, 32'(fail_cnt), 32'(ef));
    chk({tag, "_tmo_cnt"}, 32'(tmo_cnt), 32'(et));
    chk({tag, "_fail_vec"}, 32'(fail_vec), 32'(efv));
    chk({tag, "_first_fail"}, 32'(first_fail), 32'(eff));
    chk({tag, "_aborted"}, 32'(aborted), 32'(eab));
    chk({tag, "_busy_in_finish"}, 32'(busy), 32'd1);
    @(negedge sclk);
    chk({tag, "_busy_after"}, 32'(busy), 32'd0);
    chk({tag, "_done_width"}, 32'(done), 32'd0);
    @(negedge sclk);
    chk({tag, "_done_pulses"}, 32'(done_cnt - dc0), 32'd1);
  endtask

  initial begin
    int base;
    int dc0;
    int k;
    for (int i = 0; i < NT; i++) rsp_cnt[i] = 0;
    set_rsp(5, 1'b1);

    // Reset state
    repeat (3) @(negedge sclk);
    sclk_reset = 1'b0;
    @(negedge sclk);
    chk("RST_busy", 32'(busy), 32'd0);
    chk("RST_done", 32'(done), 32'd0);
    chk("RST_start", 32'(test_start), 32'd0);
    chk("RST_cur", 32'(cur_test), 32'd0);
    chk("RST_first_fail", 32'(first_fail), 32'hFF);
    chk("RST_cnts", 32'({pass_cnt, fail_cnt, tmo_cnt}), 32'd0);

    // T1: all pass
    base = start_log.size(); dc0 = done_cnt;
    do_run(10'h3FF, 1'b0, 24'd0);
    chk("T1_busy", 32'(busy), 32'd1);
    wait_done(400, "T1");
    chk("T1_nstart", 32'(start_log.size() - base), 32'd10);
    for (int i = 0; i < 10; i++) chk("T1_order", 32'(start_log[base+i]), 32'(i));
    chk("T1_cur", 32'(cur_test), 32'd9);
    end_chk("T1", dc0, 10, 0, 0, 10'h000, 8'hFF, 1'b0);

    // T2: sparse mask
    base = start_log.size(); dc0 = done_cnt;
    do_run(10'h205, 1'b0, 24'd0);
    wait_done(200, "T2");
    chk("T2_nstart", 32'(start_log.size() - base), 32'd3);
    chk("T2_order0", 32'(start_log[base]), 32'd0);
    chk("T2_order1", 32'(start_log[base+1]), 32'd2);
    chk("T2_order2", 32'(start_log[base+2]), 32'd9);
    end_chk("T2", dc0, 3, 0, 0, 10'h000, 8'hFF, 1'b0);

    // T3: fail on test 3 with stop_on_fail
    rsp_pass[3] = 1'b0;
    base = start_log.size(); dc0 = done_cnt;
    do_run(10'h3FF, 1'b1, 24'd0);
    wait_done(200, "T3");
    chk("T3_nstart", 32'(start_log.size() - base), 32'd4);
    chk("T3_last_start", 32'(start_log[start_log.size()-1]), 32'd3);
    chk("T3_cur", 32'(cur_test), 32'd3);
    end_chk("T3", dc0, 3, 1, 0, 10'h008, 8'd3, 1'b0);
    rsp_pass[3] = 1'b1;

    // T4: test 1 times out at 100; its late done lands while test 2 is running
    set_rsp(0, 1'b1);
    rsp_delay[1] = 110; rsp_pass[1] = 1'b0;
    rsp_delay[2] = 20;
    base = start_log.size(); dc0 = done_cnt;
    do_run(10'h006, 1'b0, 24'd100);
    wait_done(400, "T4");
    chk("T4_nstart", 32'(start_log.size() - base), 32'd2);
    chk("T4_start_gap", 32'(start_cyc[base+1] - start_cyc[base]), 32'd103);
    chk("T4_cur", 32'(cur_test), 32'd9);
    end_chk("T4", dc0, 1, 0, 1, 10'h002, 8'd1, 1'b0);

    // T5: done arrives on the timeout cycle
    set_rsp(8, 1'b1);
    rsp_pass[1] = 1'b0;
    dc0 = done_cnt;
    do_run(10'h003, 1'b0, 24'd8);
    wait_done(200, "T5");
    end_chk("T5", dc0, 1, 1, 0, 10'h002, 8'd1, 1'b0);

    // Empty mask
    dc0 = done_cnt;
    do_run(10'h000, 1'b0, 24'd0);
    wait_done(100, "T0");
    end_chk("T0", dc0, 0, 0, 0, 10'h000, 8'hFF, 1'b0);

    // T6: abort while test 2 is in flight
    set_rsp(5, 1'b1);
    dc0 = done_cnt;
    do_run(10'h3FF, 1'b0, 24'd0);
    k = 0;
    while (test_start[2] !== 1'b1 && k < 200) begin
      @(negedge sclk);
      k++;
    end
    chk("T6_start2_seen", 32'(test_start[2]), 32'd1);
    @(negedge sclk);
    abort = 1'b1;
    @(negedge sclk);
    abort = 1'b0;
    wait_done(5, "T6");
    end_chk("T6", dc0, 2, 0, 0, 10'h000, 8'hFF, 1'b1);

    dc0 = done_cnt;
    do_run(10'h001, 1'b0, 24'd0);
    chk("T6_aborted_cleared", 32'(aborted), 32'd0);
    wait_done(100, "T6b");
    end_chk("T6b", dc0, 1, 0, 0, 10'h000, 8'hFF, 1'b0);

    // Reset in the middle of WAIT
    rsp_delay[0] = 50;
    do_run(10'h001, 1'b0, 24'd0);
    repeat (6) @(negedge sclk);
    chk("RW_busy_before", 32'(busy), 32'd1);
    sclk_reset = 1'b1;
    repeat (2) @(negedge sclk);
    chk("RW_busy", 32'(busy), 32'd0);
    chk("RW_done", 32'(done), 32'd0);
    chk("RW_start", 32'(test_start), 32'd0);
    chk("RW_cur", 32'(cur_test), 32'd0);
    chk("RW_cnts", 32'({pass_cnt, fail_cnt, tmo_cnt}), 32'd0);
    chk("RW_fail_vec", 32'(fail_vec), 32'd0);
    chk("RW_first_fail", 32'(first_fail), 32'hFF);
    sclk_reset = 1'b0;
    dc0 = done_cnt;
    repeat (60) @(negedge sclk);
    chk("RW_no_done", 32'(done_cnt - dc0), 32'd0);
    chk("RW_idle_busy", 32'(busy), 32'd0);

    chk("START_onehot_1cyc", 32'(start_bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
